// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for a combinational 32-bit ALU.
// Accepts tagged requests, holds registered operands on the ALU for SETTLE
// cycles, then captures out/zero/neg into an in-order response FIFO.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready
// never depends on valid, and a producer keeps its payload stable while valid=1
// and ready=0 (req_* are simply ignored while req_ready=0).
// Optional feature macro: ALU_SEQ_STATS_EN (completed-op counter on stat_ops).
module alu_op_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_in1,
    input  logic [31:0]      req_in2,
    input  logic [3:0]       req_control,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic [3:0]       alu_control,
    input  logic [31:0]      alu_out,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_out,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      stat_ops
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int ENT_W  = 32 + 2 + TAG_W;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(SETTLE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                accept, push, pop;
    logic [31:0]         alu_in1_q, alu_in2_q;
    logic [3:0]          alu_control_q;
    logic [TAG_W-1:0]    tag_q;
    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [ENT_W-1:0]    head;
    logic                fifo_nonempty;

    // State register and settle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: accept only when the FIFO can absorb the result, so the
    // later push can never overflow or stall.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = (count_q < DEPTH_C);
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == LAST_WAIT) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand and tag registers; they keep their last values between ops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_control_q <= '0;
            tag_q         <= '0;
        end else if (accept) begin
            alu_in1_q     <= req_in1;
            alu_in2_q     <= req_in2;
            alu_control_q <= req_control;
            tag_q         <= req_tag;
        end
    end

    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_control = alu_control_q;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty && rsp_ready;

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {alu_out, alu_zero, alu_neg, tag_q};
    end

    assign head      = mem_q[rd_ptr_q];
    assign rsp_valid = fifo_nonempty;
    assign rsp_out   = fifo_nonempty ? head[ENT_W-1 -: 32] : 32'h0;
    assign rsp_zero  = fifo_nonempty ? head[TAG_W+1]       : 1'b0;
    assign rsp_neg   = fifo_nonempty ? head[TAG_W]         : 1'b0;
    assign rsp_tag   = fifo_nonempty ? head[TAG_W-1:0]     : '0;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops_q;

    // Saturating count of results written into the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
        end else if (push && (stat_ops_q != 16'hFFFF)) begin
            stat_ops_q <= stat_ops_q + 16'd1;
        end
    end

    assign stat_ops = stat_ops_q;
`else
    assign stat_ops = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer.
// A behavioural ALU drives the DUT's ALU inputs; a queue-based model predicts
// every response from the accepted requests and the settle delay.
module tb_alu_op_sequencer;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;
    localparam int TAG_W  = 4;
    localparam int ENT_W  = 32 + 2 + TAG_W;
`ifdef ALU_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_in1;
    logic [31:0]      req_in2;
    logic [3:0]       req_control;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      alu_in1;
    logic [31:0]      alu_in2;
    logic [3:0]       alu_control;
    logic [31:0]      alu_out;
    logic             alu_zero;
    logic             alu_neg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_out;
    logic             rsp_zero;
    logic             rsp_neg;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      stat_ops;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .req_control(req_control), .req_tag(req_tag),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
        .rsp_tag(rsp_tag), .stat_ops(stat_ops)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: {out, zero, neg}.
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'h0:    r = a + b;
            4'h1:    r = a - b;
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            default: r = a ^ b;
        endcase
        return {r, (r == 32'h0), r[31]};
    endfunction

    always_comb begin
        {alu_out, alu_zero, alu_neg} = alu_ref(alu_in1, alu_in2, alu_control);
    end

    // Reference model: pending ops with their due edge, then the response queue.
    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] pend_q[$];
    int               pend_due[$];
    int               model_ops = 0;
    int               cyc = 0;
    bit               acc_fire, pop_fire, rst_now;
    logic [ENT_W-1:0] pop_val, pop_exp, acc_ent;

    // One clock: sample handshakes before the edge, advance the model after it.
    task automatic cycle();
        int due;
        #1;
        acc_fire = req_valid && req_ready;
        pop_fire = rsp_valid && rsp_ready;
        pop_val  = {rsp_out, rsp_zero, rsp_neg, rsp_tag};
        acc_ent  = {alu_ref(req_in1, req_in2, req_control), req_tag};
        rst_now  = !rst_n;
        @(posedge clk);
        cyc++;
        pop_exp = 'x;
        if (rst_now) begin
            exp_q.delete();
            pend_q.delete();
            pend_due.delete();
            model_ops = 0;
        end else begin
            if (pop_fire && exp_q.size() > 0) pop_exp = exp_q.pop_front();
            if (pend_q.size() > 0 && pend_due[0] == cyc) begin
                exp_q.push_back(pend_q.pop_front());
                due = pend_due.pop_front();
                if (model_ops < 65535) model_ops++;
            end
            if (acc_fire) begin
                pend_q.push_back(acc_ent);
                pend_due.push_back(cyc + SETTLE);
            end
        end
        #1;
    endtask

    // Present a fresh random request.
    task automatic drive_req(input logic [TAG_W-1:0] tag);
        req_valid   = 1'b1;
        req_in1     = $urandom;
        req_in2     = ($urandom_range(0, 3) == 0) ? req_in1 : $urandom;
        req_control = 4'($urandom_range(0, 5));
        req_tag     = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_in1 = '0; req_in2 = '0; req_control = '0; req_tag = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (alu_in1 !== 32'h0) begin errors++; $display("FAIL reset_alu_in1 got=%h exp=0", alu_in1); end
        checks++; if ({alu_in2, alu_control} !== 36'h0) begin errors++; $display("FAIL reset_alu_in2_ctl got=%h exp=0", {alu_in2, alu_control}); end
        checks++; if (stat_ops !== 16'h0) begin errors++; $display("FAIL reset_stat_ops got=%h exp=0", stat_ops); end
        checks++; if ({rsp_out, rsp_zero, rsp_neg, rsp_tag} !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", {rsp_out, rsp_zero, rsp_neg, rsp_tag}); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_in1 = 32'd5; req_in2 = 32'd5; req_control = 4'h1; req_tag = 4'd3;
        cycle();
        checks++; if (acc_fire !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", acc_fire); end
        req_valid = 1'b0; req_in1 = $urandom; req_in2 = $urandom;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL single_wait_ready got=%b exp=0", req_ready); end
        checks++; if ({alu_in1, alu_in2, alu_control} !== {32'd5, 32'd5, 4'h1}) begin errors++; $display("FAIL single_alu_regs got=%h exp=%h", {alu_in1, alu_in2, alu_control}, {32'd5, 32'd5, 4'h1}); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
        cycle();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if ({rsp_out, rsp_zero, rsp_neg, rsp_tag} !== {32'h0, 1'b1, 1'b0, 4'd3}) begin errors++; $display("FAIL single_rsp_data got=%h exp=%h", {rsp_out, rsp_zero, rsp_neg, rsp_tag}, {32'h0, 1'b1, 1'b0, 4'd3}); end
        rsp_ready = 1'b1;
        cycle();
        if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL single_pop got=%h exp=%h", pop_val, pop_exp); end end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", rsp_valid); end
        checks++; if (alu_in1 !== 32'd5) begin errors++; $display("FAIL single_alu_hold got=%h exp=5", alu_in1); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_negative();
        logic [TAG_W-1:0] t;
        t = TAG_W'($urandom);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_in1 = 32'd1; req_in2 = 32'd2; req_control = 4'h1; req_tag = t;
        cycle();
        req_valid = 1'b0;
        cycle();
        checks++; if ({rsp_valid, rsp_out, rsp_zero, rsp_neg, rsp_tag} !== {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, t}) begin errors++; $display("FAIL negative_rsp got=%h exp=%h", {rsp_valid, rsp_out, rsp_zero, rsp_neg, rsp_tag}, {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, t}); end
        rsp_ready = 1'b1;
        cycle();
        if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL negative_pop got=%h exp=%h", pop_val, pop_exp); end end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n_acc, guard, bad;
        bit fifth_acc;
        logic [TAG_W-1:0] got[$];
        logic [TAG_W-1:0] want;
        logic [ENT_W-1:0] head0;
        rsp_ready = 1'b0;
        n_acc = 0; guard = 0;
        drive_req(TAG_W'(0));
        while (n_acc < DEPTH && guard < 50) begin
            cycle(); guard++;
            if (acc_fire) begin n_acc++; drive_req(TAG_W'(n_acc)); end
        end
        checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL bp_accepted got=%0d exp=%0d", n_acc, DEPTH); end
        cycle();
        head0 = {rsp_out, rsp_zero, rsp_neg, rsp_tag};
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (acc_fire || req_ready || ({rsp_out, rsp_zero, rsp_neg, rsp_tag} !== head0)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall got=%0d bad cycles exp=0", bad); end
        checks++; if ({rsp_valid, rsp_tag} !== {1'b1, TAG_W'(0)}) begin errors++; $display("FAIL bp_head got=%h exp=%h", {rsp_valid, rsp_tag}, {1'b1, TAG_W'(0)}); end
        rsp_ready = 1'b1; fifth_acc = 1'b0; guard = 0;
        while (got.size() < DEPTH + 1 && guard < 60) begin
            cycle(); guard++;
            if (acc_fire) begin fifth_acc = 1'b1; req_valid = 1'b0; end
            if (pop_fire) begin
                checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL bp_pop got=%h exp=%h", pop_val, pop_exp); end
                got.push_back(pop_val[TAG_W-1:0]);
            end
        end
        checks++; if (fifth_acc !== 1'b1) begin errors++; $display("FAIL bp_fifth_accept got=%b exp=1", fifth_acc); end
        checks++; if (got.size() !== DEPTH + 1) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), DEPTH + 1); end
        for (int i = 0; i < got.size(); i++) begin
            want = i[TAG_W-1:0];
            checks++; if (got[i] !== want) begin errors++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got[i], want); end
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int last_acc, n_acc, gap_bad, occ_bad;
        rsp_ready = 1'b1;
        last_acc = -1; n_acc = 0; gap_bad = 0; occ_bad = 0;
        drive_req(TAG_W'($urandom));
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL stream_pop got=%h exp=%h", pop_val, pop_exp); end end
            if (acc_fire) begin
                if (last_acc >= 0 && (cyc - last_acc) != SETTLE + 1) gap_bad++;
                last_acc = cyc; n_acc++;
                drive_req(TAG_W'($urandom));
            end
            if (exp_q.size() > 1 || rsp_valid !== (exp_q.size() > 0)) occ_bad++;
        end
        req_valid = 1'b0;
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL stream_gap got=%0d bad gaps exp=0", gap_bad); end
        checks++; if (occ_bad !== 0) begin errors++; $display("FAIL stream_occupancy got=%0d bad cycles exp=0", occ_bad); end
        checks++; if (n_acc < 40 / (SETTLE + 1) - 1) begin errors++; $display("FAIL stream_rate got=%0d accepts exp>=%0d", n_acc, 40 / (SETTLE + 1) - 1); end
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL stream_drain got=%h exp=%h", pop_val, pop_exp); end end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int guard, stale;
        rsp_ready = 1'b0; guard = 0;
        drive_req(TAG_W'($urandom));
        while (exp_q.size() < 2 && guard < 20) begin
            cycle(); guard++;
            if (acc_fire) drive_req(TAG_W'($urandom));
        end
        guard = 0; acc_fire = 1'b0;
        while (!acc_fire && guard < 20) begin cycle(); guard++; end
        req_valid = 1'b0;
        checks++; if ({acc_fire, rsp_valid, req_ready} !== 3'b110) begin errors++; $display("FAIL midop_setup got=%b exp=110", {acc_fire, rsp_valid, req_ready}); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL midop_after_reset got=%b exp=01", {rsp_valid, req_ready}); end
        checks++; if (stat_ops !== 16'h0) begin errors++; $display("FAIL midop_stat_ops got=%h exp=0", stat_ops); end
        rsp_ready = 1'b1; stale = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rsp_valid || pop_fire) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL midop_stale got=%0d cycles exp=0", stale); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_stats();
        int n_acc, guard;
        logic [15:0] want;
        rsp_ready = 1'b1; n_acc = 0; guard = 0;
        drive_req(TAG_W'($urandom));
        while (n_acc < 3 && guard < 30) begin
            cycle(); guard++;
            if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL stats_pop got=%h exp=%h", pop_val, pop_exp); end end
            if (acc_fire) begin n_acc++; if (n_acc < 3) drive_req(TAG_W'($urandom)); else req_valid = 1'b0; end
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL stats_pop got=%h exp=%h", pop_val, pop_exp); end end
        end
        want = STATS ? 16'd3 : 16'd0;
        checks++; if (stat_ops !== want) begin errors++; $display("FAIL stats_count got=%0d exp=%0d", stat_ops, want); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] want_stat;
        for (int i = 0; i < 300; i++) begin
            req_valid   = ($urandom_range(0, 1) == 1);
            req_in1     = $urandom;
            req_in2     = ($urandom_range(0, 3) == 0) ? req_in1 : $urandom;
            req_control = 4'($urandom_range(0, 5));
            req_tag     = TAG_W'($urandom);
            rsp_ready   = ($urandom_range(0, 9) < 4);
            cycle();
            if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL random_pop got=%h exp=%h", pop_val, pop_exp); end end
            checks++; if (req_ready !== (pend_q.size() == 0 && exp_q.size() < DEPTH)) begin errors++; $display("FAIL random_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, (pend_q.size() == 0 && exp_q.size() < DEPTH)); end
            checks++; if (rsp_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL random_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (exp_q.size() > 0)); end
            if (exp_q.size() > 0) begin
                checks++; if ({rsp_out, rsp_zero, rsp_neg, rsp_tag} !== exp_q[0]) begin errors++; $display("FAIL random_head cyc=%0d got=%h exp=%h", cyc, {rsp_out, rsp_zero, rsp_neg, rsp_tag}, exp_q[0]); end
            end
            want_stat = STATS ? 16'(model_ops) : 16'h0;
            checks++; if (stat_ops !== want_stat) begin errors++; $display("FAIL random_stat_ops cyc=%0d got=%0d exp=%0d", cyc, stat_ops, want_stat); end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (pop_fire) begin checks++; if (pop_val !== pop_exp) begin errors++; $display("FAIL random_drain got=%h exp=%h", pop_val, pop_exp); end end
        end
        checks++; if ({rsp_valid, 1'(exp_q.size() > 0), 1'(pend_q.size() > 0)} !== 3'b000) begin errors++; $display("FAIL random_final got=%b exp=000", {rsp_valid, 1'(exp_q.size() > 0), 1'(pend_q.size() > 0)}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_backpressure();
        test_streaming();
        test_reset_midop();
        test_stats();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
